// File: rtl/ctrl_pkg.sv
// Shared constants for the multicycle controller: opcodes, state encodings,
// ALU operation codes, mux select codes and trap causes.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_WB_R     = 4'd8,
        S_BRANCH   = 4'd9,
        S_EXEC_I   = 4'd10,
        S_WB_I     = 4'd11,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRC_B_REG = 2'b00;
    localparam logic [1:0] SRC_B_ONE = 2'b01;
    localparam logic [1:0] SRC_B_SX  = 2'b10;
    localparam logic [1:0] SRC_B_BR  = 2'b11;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

    // States that hold a memory request open and are guarded by the watchdog.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/ack_watchdog.sv
// Wait-cycle counter for memory handshakes; flags expiry on the last
// allowed wait cycle that passes without an ack.
module ack_watchdog #(
    parameter int ACK_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic wait_en,
    input  logic ack,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(ACK_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (wait_en && !ack) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // An ack arriving on the final wait cycle still completes the access.
    assign expire = wait_en && !ack && (cnt == LAST_WAIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute over a shared
// memory with req/ack handshake and traps on illegal opcodes or lost acks.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | halted between instructions, waiting for run
// FETCH    | read instruction at PC; on ack load IR and PC+1
// DECODE   | compute branch target into ALUOut, dispatch on opcode
// MEM_ADDR | ALUOut = rs + sx offset for lw/sw
// MEM_RD   | data read at ALUOut, wait for ack
// MEM_WB   | write MDR to Rt
// MEM_WR   | data write at ALUOut, wait for ack
// EXEC_R   | funct-decoded ALU op on rs, rt
// WB_R     | write ALUOut to Rd
// BRANCH   | compare rs, rt; load PC from ALUOut if equal
// EXEC_I   | rs + sx immediate
// WB_I     | write ALUOut to Rt
// TRAP     | halted with cause latched; only reset leaves
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [5:0] opcode,
    input  logic       mem_ack,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       instr_retired,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_next;
    state_t boundary_state;
    logic   wd_expire;

    ack_watchdog #(
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_next != state_q),
        .wait_en(is_mem_state(state_q)),
        .ack    (mem_ack),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Cause is latched on the transition into TRAP; DECODE only traps on opcode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_cause <= TRAP_NONE;
        end else if (state_q != S_TRAP && state_next == S_TRAP) begin
            trap_cause <= (state_q == S_DECODE) ? TRAP_ILLEGAL : TRAP_TIMEOUT;
        end
    end

    assign boundary_state = run ? S_FETCH : S_IDLE;

    always_comb begin
        state_next = state_q;
        case (state_q)
            S_IDLE:     if (run) state_next = S_FETCH;
            S_FETCH: begin
                if (wd_expire)    state_next = S_TRAP;
                else if (mem_ack) state_next = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_next = S_EXEC_R;
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_EXEC_I;
                    default:      state_next = S_TRAP;
                endcase
            end
            S_MEM_ADDR: state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (wd_expire)    state_next = S_TRAP;
                else if (mem_ack) state_next = S_MEM_WB;
            end
            S_MEM_WR: begin
                if (wd_expire)    state_next = S_TRAP;
                else if (mem_ack) state_next = boundary_state;
            end
            S_EXEC_R:   state_next = S_WB_R;
            S_EXEC_I:   state_next = S_WB_I;
            S_MEM_WB, S_WB_R, S_BRANCH, S_WB_I: state_next = boundary_state;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_IDLE;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_REG;
        alu_op        = ALU_OP_ADD;
        instr_retired = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_ONE;
                ir_write  = mem_ack;
                pc_write  = mem_ack;
            end
            S_DECODE: alu_src_b = SRC_B_BR;
            S_MEM_ADDR, S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_SX;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write     = 1'b1;
                mem_to_reg    = 1'b1;
                instr_retired = 1'b1;
            end
            S_MEM_WR: begin
                mem_write     = 1'b1;
                i_or_d        = 1'b1;
                instr_retired = mem_ack;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_FUNCT;
            end
            S_WB_R: begin
                reg_write     = 1'b1;
                reg_dst       = 1'b1;
                instr_retired = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_OP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 1'b1;
                instr_retired = 1'b1;
            end
            S_WB_I: begin
                reg_write     = 1'b1;
                instr_retired = 1'b1;
            end
            default: ;
        endcase
    end

    assign trap  = (state_q == S_TRAP);
    assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: expected per-cycle state/control
// traces are built from instruction latency rules and random ack delays.
module tb_multicycle_ctrl;

    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [5:0] opcode;
    logic       mem_ack;
    logic       pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write;
    logic       ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       instr_retired, trap;
    logic [1:0] trap_cause;
    logic [3:0] state;
    logic [15:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_ctrl #(.ACK_TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem_ack(mem_ack),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .instr_retired(instr_retired), .trap(trap),
        .trap_cause(trap_cause), .state(state)
    );

    always #5 clk = ~clk;

    assign obs = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                  ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                  alu_src_b, alu_op, instr_retired};

    // Expected control word for a state number, straight from the per-state control list.
    function automatic logic [15:0] exp_ctrl(input int st, input bit ack);
        logic pw, pwc, psrc, iod, mr, mw, irw, rd, m2r, rw, sa, ret;
        logic [1:0] sb, aop;
        pw = 0; pwc = 0; psrc = 0; iod = 0; mr = 0; mw = 0; irw = 0;
        rd = 0; m2r = 0; rw = 0; sa = 0; ret = 0; sb = 2'b00; aop = 2'b00;
        case (st)
            1:     begin mr = 1; sb = 2'b01; pw = ack; irw = ack; end
            2:     sb = 2'b11;
            3, 10: begin sa = 1; sb = 2'b10; end
            4:     begin mr = 1; iod = 1; end
            5:     begin rw = 1; m2r = 1; ret = 1; end
            6:     begin mw = 1; iod = 1; ret = ack; end
            7:     begin sa = 1; aop = 2'b10; end
            8:     begin rw = 1; rd = 1; ret = 1; end
            9:     begin sa = 1; aop = 2'b01; pwc = 1; psrc = 1; ret = 1; end
            11:    begin rw = 1; ret = 1; end
            default: ;
        endcase
        return {pw, pwc, psrc, iod, mr, mw, irw, rd, m2r, rw, sa, sb, aop, ret};
    endfunction

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; mem_ack = 1'b0; opcode = 6'h00;
        @(negedge clk); #1;
        n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state act=%0d exp=0", state); end
        n_checks++; if (obs !== 16'h0) begin n_fail++; $display("FAIL reset_ctrl act=%h exp=0000", obs); end
        n_checks++; if (trap !== 1'b0 || trap_cause !== 2'b00) begin
            n_fail++; $display("FAIL reset_trap act=%b/%b exp=0/00", trap, trap_cause); end
        rst = 1'b0;
    endtask

    task automatic go_fetch();
        run = 1'b1; mem_ack = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (state !== 4'd1) begin n_fail++; $display("FAIL go_fetch act=%0d exp=1", state); end
    endtask

    // Expects the DUT in the first FETCH cycle; leaves it in the first cycle of whatever follows.
    task automatic run_instr(input logic [5:0] op, input int wf, input int wm,
                             input bit run_mid, input string name);
        int st_q[$];
        bit ack_q[$];
        int end_st;
        logic [1:0] end_cause;
        int exp_ret;
        int got_ret;
        bit legal, timeout;
        int n;
        got_ret = 0;
        legal = (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h08);
        timeout = legal && (op == 6'h23 || op == 6'h2B) && (wm >= TIMEOUT);
        for (int i = 0; i < wf; i++) begin st_q.push_back(1); ack_q.push_back(1'b0); end
        st_q.push_back(1); ack_q.push_back(1'b1);
        st_q.push_back(2); ack_q.push_back(1'($urandom_range(0, 1)));
        if (op == 6'h23 || op == 6'h2B) begin
            st_q.push_back(3); ack_q.push_back(1'($urandom_range(0, 1)));
            n = timeout ? TIMEOUT : wm;
            for (int i = 0; i < n; i++) begin
                st_q.push_back(op == 6'h23 ? 4 : 6); ack_q.push_back(1'b0);
            end
            if (!timeout) begin
                st_q.push_back(op == 6'h23 ? 4 : 6); ack_q.push_back(1'b1);
                if (op == 6'h23) begin st_q.push_back(5); ack_q.push_back(1'($urandom_range(0, 1))); end
            end
        end else if (op == 6'h00) begin
            st_q.push_back(7); ack_q.push_back(1'($urandom_range(0, 1)));
            st_q.push_back(8); ack_q.push_back(1'($urandom_range(0, 1)));
        end else if (op == 6'h04) begin
            st_q.push_back(9); ack_q.push_back(1'($urandom_range(0, 1)));
        end else if (op == 6'h08) begin
            st_q.push_back(10); ack_q.push_back(1'($urandom_range(0, 1)));
            st_q.push_back(11); ack_q.push_back(1'($urandom_range(0, 1)));
        end
        if (!legal)       begin end_st = 15; end_cause = 2'b01; exp_ret = 0; end
        else if (timeout) begin end_st = 15; end_cause = 2'b10; exp_ret = 0; end
        else              begin end_st = run_mid ? 1 : 0; end_cause = 2'b00; exp_ret = 1; end

        opcode = op;
        run = run_mid;
        for (int i = 0; i < st_q.size(); i++) begin
            mem_ack = ack_q[i];
            #1;
            n_checks++; if (state !== 4'(st_q[i])) begin
                n_fail++; $display("FAIL %s state[%0d] act=%0d exp=%0d", name, i, state, st_q[i]); end
            n_checks++; if (obs !== exp_ctrl(st_q[i], ack_q[i])) begin
                n_fail++; $display("FAIL %s ctrl[%0d] st=%0d act=%h exp=%h", name, i, st_q[i], obs, exp_ctrl(st_q[i], ack_q[i])); end
            n_checks++; if (trap !== 1'b0) begin
                n_fail++; $display("FAIL %s early_trap[%0d] act=%b exp=0", name, i, trap); end
            got_ret += int'(instr_retired);
            @(negedge clk);
        end
        mem_ack = 1'b0;
        #1;
        n_checks++; if (state !== 4'(end_st)) begin
            n_fail++; $display("FAIL %s end_state act=%0d exp=%0d", name, state, end_st); end
        n_checks++; if (obs !== exp_ctrl(end_st, 1'b0)) begin
            n_fail++; $display("FAIL %s end_ctrl act=%h exp=%h", name, obs, exp_ctrl(end_st, 1'b0)); end
        n_checks++; if (trap !== (end_st == 15) || trap_cause !== end_cause) begin
            n_fail++; $display("FAIL %s trap act=%b/%b exp=%b/%b", name, trap, trap_cause, end_st == 15, end_cause); end
        n_checks++; if (got_ret != exp_ret) begin
            n_fail++; $display("FAIL %s retired act=%0d exp=%0d", name, got_ret, exp_ret); end
    endtask

    task automatic test_lw();
        run_instr(6'h23, 1, 1, 1'b1, "lw_basic");
    endtask

    task automatic test_rtype_beq();
        run_instr(6'h00, 0, 0, 1'b1, "rtype");
        run_instr(6'h04, 2, 0, 1'b1, "beq");
    endtask

    task automatic test_run_drop();
        run_instr(6'h2B, 1, 3, 1'b0, "sw_run_drop");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_checks++; if (state !== 4'd0 || mem_read !== 1'b0) begin
                n_fail++; $display("FAIL run_drop_idle act=%0d/%b exp=0/0", state, mem_read); end
        end
        go_fetch();
    endtask

    task automatic test_ack_edge();
        run_instr(6'h2B, TIMEOUT - 1, TIMEOUT - 1, 1'b1, "sw_ack_last");
        run_instr(6'h23, 0, TIMEOUT - 1, 1'b1, "lw_ack_last");
    endtask

    task automatic test_random();
        logic [5:0] ops [5];
        logic [5:0] op;
        bit r;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08};
        for (int k = 0; k < 25; k++) begin
            op = ops[$urandom_range(0, 4)];
            r = ($urandom_range(0, 3) != 0);
            run_instr(op, $urandom_range(0, 4), $urandom_range(0, 6), r, "random");
            if (!r) go_fetch();
        end
    endtask

    task automatic test_illegal();
        run_instr(6'h3F, 1, 0, 1'b1, "illegal");
        for (int i = 0; i < 6; i++) begin
            run = 1'($urandom_range(0, 1));
            mem_ack = 1'($urandom_range(0, 1));
            @(negedge clk); #1;
            n_checks++; if (state !== 4'd15 || obs !== 16'h0 || trap !== 1'b1 || trap_cause !== 2'b01) begin
                n_fail++; $display("FAIL trap_sticky act=%0d/%h/%b/%b exp=15/0000/1/01", state, obs, trap, trap_cause); end
        end
    endtask

    task automatic test_timeout();
        run_instr(6'h2B, 0, TIMEOUT, 1'b1, "sw_timeout");
        @(negedge clk); #1;
        n_checks++; if (state !== 4'd15 || mem_write !== 1'b0 || trap_cause !== 2'b10) begin
            n_fail++; $display("FAIL timeout_hold act=%0d/%b/%b exp=15/0/10", state, mem_write, trap_cause); end
    endtask

    task automatic test_rst_mid();
        bit hit;
        hit = 1'b0;
        opcode = 6'h23;
        for (int c = 0; c < 20 && !hit; c++) begin
            mem_ack = (state == 4'd1);
            @(negedge clk); #1;
            if (state == 4'd4) hit = 1'b1;
        end
        mem_ack = 1'b0;
        n_checks++; if (!hit || mem_read !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_reach act=%0d/%b exp=4/1", state, mem_read); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (state !== 4'd0 || obs !== 16'h0) begin
            n_fail++; $display("FAIL rst_mid_async act=%0d/%h exp=0/0000", state, obs); end
        @(negedge clk);
        rst = 1'b0;
        go_fetch();
        run_instr(6'h08, 1, 0, 1'b1, "addi_after_rst");
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; mem_ack = 1'b0; opcode = 6'h00;
        test_reset();
        go_fetch();
        test_lw();
        test_rtype_beq();
        test_run_drop();
        test_ack_edge();
        test_random();
        test_illegal();
        test_reset();
        go_fetch();
        test_timeout();
        test_reset();
        go_fetch();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit act=expired req=finish");
        $fatal(1, "time limit");
    end

endmodule
